// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared fault-tolerance constants, state encoding and decode helpers
package ft_pkg;

    typedef enum logic {
        ST_MONITOR = 1'b0,
        ST_FLAGGED = 1'b1
    } ft_state_t;

    // Bit positions inside the {reg_write, mem_write, mem_read, branch} bundle
    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_BRANCH    = 0;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    // A memory op cannot both read and write, and a branch never touches memory
    function automatic logic is_invalid_ctrl(input logic [3:0] ctrl);
        return (ctrl[CTRL_MEM_READ] & ctrl[CTRL_MEM_WRITE])
             | (ctrl[CTRL_BRANCH] & (ctrl[CTRL_MEM_READ] | ctrl[CTRL_MEM_WRITE]));
    endfunction

endpackage

// File: rtl/stuck_at_tracker.sv
// rtl/stuck_at_tracker.sv - saturating control-mismatch counter with threshold compare
module stuck_at_tracker #(
    parameter int STUCK_THRESH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic mismatch,
    input  logic clear,
    output logic stuck
);

    logic [3:0] count_q;
    logic [3:0] count_next;

    // Freeze whenever sample is low; a sampled match restarts the run
    always_comb begin
        count_next = count_q;
        if (sample) begin
            if (mismatch) begin
                count_next = (count_q == 4'hf) ? 4'hf : count_q + 4'd1;
            end else begin
                count_next = 4'd0;
            end
        end
    end

    assign stuck = sample && (count_next >= 4'(STUCK_THRESH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else if (clear) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/fault_detect_checkpoint.sv
// rtl/fault_detect_checkpoint.sv - fault flag producer and committed-PC checkpoint
module fault_detect_checkpoint
    import ft_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          STUCK_THRESH = 4,
    parameter int          MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [6:0]  opcode,
    input  logic [3:0]  ctrl_obs,
    input  logic [3:0]  ctrl_exp,
    input  logic        commit,
    input  logic [31:0] pc_current,
    input  logic        recovery_done,
    output logic        illegal_opcode,
    output logic        invalid_control,
    output logic        stuck_at_fault,
    output logic [31:0] pc_saved,
    output logic        fault_pending,
    output logic [2:0]  retry_count
);

    ft_state_t state_q;
    ft_state_t state_next;

    logic sample;
    logic chk_illegal;
    logic chk_invalid;
    logic chk_minor;
    logic chk_escalate;
    logic chk_stuck;
    logic trk_stuck;
    logic fault;
    logic recover;
    logic clean_commit;

    assign sample       = (state_q == ST_MONITOR) && instr_valid;
    assign chk_illegal  = sample && !is_legal_opcode(opcode);
    assign chk_invalid  = sample && is_invalid_ctrl(ctrl_obs);
    assign chk_minor    = chk_illegal || chk_invalid;
    // Too many minor retries at one checkpoint means the hardware is not healing
    assign chk_escalate = chk_minor && !trk_stuck && (retry_count == 3'(MAX_RETRY));
    assign chk_stuck    = trk_stuck || chk_escalate;
    assign fault        = chk_minor || chk_stuck;
    assign recover      = (state_q == ST_FLAGGED) && recovery_done;
    assign clean_commit = (state_q == ST_MONITOR) && commit && !fault;

    stuck_at_tracker #(
        .STUCK_THRESH (STUCK_THRESH)
    ) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .sample   (sample),
        .mismatch (ctrl_obs != ctrl_exp),
        .clear    (recover && stuck_at_fault),
        .stuck    (trk_stuck)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_MONITOR;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_MONITOR: if (fault)         state_next = ST_FLAGGED;
            ST_FLAGGED: if (recovery_done) state_next = ST_MONITOR;
            default:                       state_next = ST_MONITOR;
        endcase
    end

    always_comb begin
        fault_pending = (state_q == ST_FLAGGED);
    end

    // Flags are levels for the recovery FSM: set together, cleared together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_opcode  <= 1'b0;
            invalid_control <= 1'b0;
            stuck_at_fault  <= 1'b0;
        end else if (fault) begin
            illegal_opcode  <= chk_illegal;
            invalid_control <= chk_invalid;
            stuck_at_fault  <= chk_stuck;
        end else if (recover) begin
            illegal_opcode  <= 1'b0;
            invalid_control <= 1'b0;
            stuck_at_fault  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_saved    <= RESET_PC;
            retry_count <= 3'd0;
        end else if (clean_commit) begin
            pc_saved    <= pc_current;
            retry_count <= 3'd0;
        end else if (recover) begin
            if (stuck_at_fault) begin
                retry_count <= 3'd0;
            end else if (retry_count != 3'd7) begin
                retry_count <= retry_count + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_fault_detect_checkpoint.sv
// tb/tb_fault_detect_checkpoint.sv - scoreboard bench with behavioural model for fault_detect_checkpoint
module tb_fault_detect_checkpoint;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          STUCK_THRESH = 4;
    localparam int          MAX_RETRY    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic [3:0]  ctrl_obs;
    logic [3:0]  ctrl_exp;
    logic        commit;
    logic [31:0] pc_current;
    logic        recovery_done;
    logic        illegal_opcode;
    logic        invalid_control;
    logic        stuck_at_fault;
    logic [31:0] pc_saved;
    logic        fault_pending;
    logic [2:0]  retry_count;

    fault_detect_checkpoint #(
        .RESET_PC     (RESET_PC),
        .STUCK_THRESH (STUCK_THRESH),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .opcode          (opcode),
        .ctrl_obs        (ctrl_obs),
        .ctrl_exp        (ctrl_exp),
        .commit          (commit),
        .pc_current      (pc_current),
        .recovery_done   (recovery_done),
        .illegal_opcode  (illegal_opcode),
        .invalid_control (invalid_control),
        .stuck_at_fault  (stuck_at_fault),
        .pc_saved        (pc_saved),
        .fault_pending   (fault_pending),
        .retry_count     (retry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        bit          inv;
        bit          stk;
        bit          pend;
        logic [31:0] pc;
        int          retry;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    event mon_ev;

    logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

    // Reference model state
    bit          m_flagged;
    bit          m_ill, m_inv, m_stk;
    logic [31:0] m_pc;
    int          m_retry;
    int          m_run;

    function automatic exp_t snapshot();
        exp_t e;
        e.ill = m_ill; e.inv = m_inv; e.stk = m_stk; e.pend = m_flagged;
        e.pc = m_pc; e.retry = m_retry;
        return e;
    endfunction

    task automatic model_reset();
        m_flagged = 0; m_ill = 0; m_inv = 0; m_stk = 0;
        m_pc = RESET_PC; m_retry = 0; m_run = 0;
    endtask

    task automatic model_step();
        bit ill, inv, stk, legal;
        if (!reset) begin
            model_reset();
        end else if (m_flagged) begin
            if (recovery_done) begin
                if (m_stk) begin
                    m_retry = 0;
                    m_run   = 0;
                end else begin
                    m_retry = (m_retry < 7) ? m_retry + 1 : 7;
                end
                m_ill = 0; m_inv = 0; m_stk = 0;
                m_flagged = 0;
            end
        end else begin
            ill = 0; inv = 0; stk = 0;
            if (instr_valid) begin
                legal = 0;
                foreach (legal_ops[i]) if (legal_ops[i] == opcode) legal = 1;
                ill = !legal;
                inv = (ctrl_obs[1] && ctrl_obs[2]) || (ctrl_obs[0] && (ctrl_obs[1] || ctrl_obs[2]));
                m_run = (ctrl_obs != ctrl_exp) ? ((m_run < 15) ? m_run + 1 : 15) : 0;
                stk = (m_run >= STUCK_THRESH);
                if ((ill || inv) && !stk && m_retry == MAX_RETRY) stk = 1;
            end
            if (ill || inv || stk) begin
                m_ill = ill; m_inv = inv; m_stk = stk;
                m_flagged = 1;
            end else if (commit) begin
                m_pc = pc_current;
                m_retry = 0;
            end
        end
    endtask

    always @(negedge clk) -> mon_ev;

    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (illegal_opcode === e.ill && invalid_control === e.inv && stuck_at_fault === e.stk &&
                    fault_pending === e.pend && pc_saved === e.pc && retry_count === 3'(e.retry)) begin
                    passed++;
                end else begin
                    $display("FAIL outputs @cycle %0d: got ill=%b inv=%b stk=%b pend=%b pc=%h retry=%0d, expected ill=%b inv=%b stk=%b pend=%b pc=%h retry=%0d",
                             cyc, illegal_opcode, invalid_control, stuck_at_fault, fault_pending, pc_saved, retry_count,
                             e.ill, e.inv, e.stk, e.pend, e.pc, e.retry);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        sb.push_back(snapshot());
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        instr_valid = 0; opcode = 7'b0110011; ctrl_obs = 4'b1000; ctrl_exp = 4'b1000;
        commit = 0; pc_current = 32'h0; recovery_done = 0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [3:0] obs, input logic [3:0] exp_c,
                         input logic cmt, input logic [31:0] pc);
        idle();
        instr_valid = 1; opcode = op; ctrl_obs = obs; ctrl_exp = exp_c;
        commit = cmt; pc_current = pc;
        cycle();
        idle();
    endtask

    task automatic recover_pulse();
        idle();
        recovery_done = 1;
        cycle();
        idle();
    endtask

    initial begin
        int mis_pct;
        reset = 0;
        idle();
        model_reset();
        cycle();
        cycle();
        reset = 1;
        cycle();

        // Illegal opcode, held for 10 cycles, then recovered
        issue(7'b0000000, 4'b1000, 4'b1000, 0, 32'h0);
        repeat (10) cycle();
        recover_pulse();
        cycle();

        // Clean commits then commit colliding with invalid control
        issue(7'b0110011, 4'b1000, 4'b1000, 1, 32'h100);
        issue(7'b0110011, 4'b1000, 4'b1000, 1, 32'h104);
        issue(7'b0000011, 4'b0110, 4'b0110, 1, 32'h108);
        cycle();
        recover_pulse();

        // Four consecutive mismatches declare stuck
        repeat (4) issue(7'b0110011, 4'b1000, 4'b0000, 0, 32'h10c);
        cycle();
        recover_pulse();
        // Three mismatches then a match: no flag
        repeat (3) issue(7'b0110011, 4'b1000, 4'b0000, 0, 32'h10c);
        issue(7'b0110011, 4'b1000, 4'b1000, 0, 32'h10c);
        repeat (3) issue(7'b0110011, 4'b1000, 4'b0000, 0, 32'h10c);
        issue(7'b0110011, 4'b1000, 4'b1000, 0, 32'h10c);

        // Retry escalation at one checkpoint
        issue(7'b0110011, 4'b1000, 4'b1000, 1, 32'h110);
        repeat (4) begin
            issue(7'b1111111, 4'b1000, 4'b1000, 0, 32'h114);
            cycle();
            recover_pulse();
        end

        // Recovery instruction on the same edge is not checked
        idle();
        recovery_done = 0;
        issue(7'b0000000, 4'b1000, 4'b1000, 0, 32'h0);
        idle();
        recovery_done = 1; instr_valid = 1; opcode = 7'b0000000;
        cycle();
        idle();
        cycle();

        // Reset in the middle of FLAGGED
        issue(7'b0110011, 4'b1000, 4'b1000, 1, 32'h200);
        issue(7'b0000000, 4'b1000, 4'b1000, 0, 32'h204);
        cycle();
        reset = 0;
        #1;
        model_reset();
        sb.push_back(snapshot());
        -> mon_ev;
        #1;
        cycle();
        reset = 1;
        cycle();
        // recovery_done while monitoring changes nothing
        issue(7'b0110011, 4'b1000, 4'b1000, 1, 32'h300);
        recover_pulse();
        cycle();

        // Randomized traffic with phases of heavy control mismatch
        for (int n = 0; n < 3000; n++) begin
            mis_pct = ((n / 400) % 2 == 1) ? 70 : 10;
            idle();
            instr_valid = ($urandom_range(0, 99) < 70);
            opcode = ($urandom_range(0, 99) < 85) ? legal_ops[$urandom_range(0, 9)] : 7'($urandom);
            ctrl_obs = 4'($urandom);
            if ($urandom_range(0, 2) != 0) ctrl_obs = {ctrl_obs[3], 1'b0, ctrl_obs[1], 1'b0};
            ctrl_exp = ($urandom_range(0, 99) < mis_pct) ? 4'($urandom) : ctrl_obs;
            commit = ($urandom_range(0, 99) < 40);
            pc_current = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            recovery_done = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 599) == 0) reset = 0;
            cycle();
            reset = 1;
        end
        idle();
        cycle();
        cycle();

        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
